// File: rtl/banked_coef_sram_if.sv
// Bus bundle for banked_coef_sram: shared write port, per-bank read ports.
// master drives CEN/WEN/CADDR/D/A; slave returns Q and RDY.
interface banked_coef_sram_if #(
  parameter int BLKS = 8,
  parameter int AW   = 8,
  parameter int BW   = 3,
  parameter int DW   = 20
);
  logic                 CEN;
  logic                 WEN;
  logic [BW+AW-1:0]     CADDR;
  logic [DW-1:0]        D;
  logic [BLKS*AW-1:0]   A;
  logic [BLKS*DW-1:0]   Q;
  logic                 RDY;

  modport master (
    output CEN,
    output WEN,
    output CADDR,
    output D,
    output A,
    input  Q,
    input  RDY
  );

  modport slave (
    input  CEN,
    input  WEN,
    input  CADDR,
    input  D,
    input  A,
    output Q,
    output RDY
  );
endinterface

// File: rtl/banked_coef_sram.sv
// Multi-bank coefficient memory: one shared write port, BLKS registered
// read ports, self-clearing init after reset, selectable collision mode.
// Ports: clk, rst (async high), bus (slave: CEN WEN CADDR D A -> Q RDY).
module banked_coef_sram #(
  parameter int BLKS        = 8,
  parameter int AW          = 8,
  parameter int BW          = 3,
  parameter int DW          = 20,
  parameter int WRITE_FIRST = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  banked_coef_sram_if.slave    bus
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]    state_q;
  logic [0:0]    state_d;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;

  logic          ready;
  logic          rd_en;
  logic          wr_acc;
  logic [BW-1:0] wbank;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_READY;
        end
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // During init the write port is hijacked by the clear counter and
  // every bank writes zero at the same word each cycle.
  always_comb begin
    ready  = (state_q == ST_READY);
    rd_en  = ready & ~bus.CEN;
    wr_acc = rd_en & ~bus.WEN;
    wbank  = bus.CADDR[BW+AW-1:AW];
    waddr  = ready ? bus.CADDR[AW-1:0] : cnt_q[AW-1:0];
    wdata  = ready ? bus.D : '0;
  end

  assign bus.RDY = ready;

  for (genvar b = 0; b < BLKS; b++) begin : g_bank
    logic          we;
    logic [AW-1:0] ra;
    logic [DW-1:0] q_q;
    logic [DW-1:0] q_d;
    logic [DW-1:0] mem_q [DEPTH];

    // Bank indices >= BLKS never match, so such writes vanish.
    assign we = ~ready | (wr_acc & (wbank == BW'(b)));
    assign ra = bus.A[b*AW +: AW];

    always_ff @(posedge clk) begin
      if (we) begin
        mem_q[waddr] <= wdata;
      end
    end

    // Non-blocking read of mem_q gives old data on a collision unless
    // write-first bypasses the incoming word.
    always_comb begin
      q_d = mem_q[ra];
      if (WRITE_FIRST != 0 && we && waddr == ra) begin
        q_d = wdata;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        q_q <= '0;
      end else if (rd_en) begin
        q_q <= q_d;
      end
    end

    assign bus.Q[b*DW +: DW] = q_q;
  end

endmodule

// File: tb/tb_banked_coef_sram.sv
// Directed bench for banked_coef_sram: init, table vectors, fill/readback,
// reset mid-stream, write-old collision and out-of-range bank writes.
module tb_banked_coef_sram;

  logic clk;
  logic rst;

  int total;
  int bad;

  banked_coef_sram_if #(.BLKS(8), .AW(8), .BW(3), .DW(20)) b0 ();
  banked_coef_sram_if #(.BLKS(6), .AW(4), .BW(3), .DW(20)) b1 ();

  banked_coef_sram #(
    .BLKS(8), .AW(8), .BW(3), .DW(20), .WRITE_FIRST(1)
  ) u0 (
    .clk(clk),
    .rst(rst),
    .bus(b0)
  );

  banked_coef_sram #(
    .BLKS(6), .AW(4), .BW(3), .DW(20), .WRITE_FIRST(0)
  ) u1 (
    .clk(clk),
    .rst(rst),
    .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        cen;
    logic        wen;
    logic [2:0]  bank;
    logic [7:0]  word;
    logic [19:0] d;
    logic [7:0]  a;
    int          rb;
    logic [19:0] exp;
  } vec_t;

  vec_t vt [12];
  logic [19:0] m [8][256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [159:0] act,
                     input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (!b0.RDY && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic wr0(input logic [10:0] ca, input logic [19:0] d);
    b0.CEN = 1'b0;
    b0.WEN = 1'b0;
    b0.CADDR = ca;
    b0.D = d;
    tick();
  endtask

  task automatic wr1(input logic [6:0] ca, input logic [19:0] d,
                     input logic [3:0] a);
    b1.CEN = 1'b0;
    b1.WEN = 1'b0;
    b1.CADDR = ca;
    b1.D = d;
    b1.A = {6{a}};
    tick();
  endtask

  initial begin
    int n;
    logic [7:0] ra [8];
    total = 0;
    bad = 0;
    rst = 1'b1;
    b0.CEN = 1'b1;
    b0.WEN = 1'b1;
    b0.CADDR = '0;
    b0.D = '0;
    b0.A = '0;
    b1.CEN = 1'b1;
    b1.WEN = 1'b1;
    b1.CADDR = '0;
    b1.D = '0;
    b1.A = '0;

    vt[0]  = '{1'b0, 1'b0, 3'd0, 8'h05, 20'h00055, 8'h05, 0, 20'h00055};
    vt[1]  = '{1'b0, 1'b1, 3'd0, 8'h00, 20'h00000, 8'h05, 0, 20'h00055};
    vt[2]  = '{1'b0, 1'b0, 3'd3, 8'h10, 20'hABCDE, 8'h11, 3, 20'h00000};
    vt[3]  = '{1'b0, 1'b1, 3'd0, 8'h00, 20'h00000, 8'h10, 3, 20'hABCDE};
    vt[4]  = '{1'b0, 1'b0, 3'd3, 8'h10, 20'h12345, 8'h10, 3, 20'h12345};
    vt[5]  = '{1'b0, 1'b0, 3'd2, 8'h07, 20'h11111, 8'h10, 3, 20'h12345};
    vt[6]  = '{1'b0, 1'b1, 3'd0, 8'h00, 20'h00000, 8'h07, 2, 20'h11111};
    vt[7]  = '{1'b0, 1'b1, 3'd0, 8'h00, 20'h00000, 8'h05, 0, 20'h00055};
    vt[8]  = '{1'b1, 1'b0, 3'd0, 8'h05, 20'hFFFFF, 8'h09, 0, 20'h00055};
    vt[9]  = '{1'b1, 1'b1, 3'd0, 8'h00, 20'h00000, 8'h09, 2, 20'h00000};
    vt[10] = '{1'b0, 1'b1, 3'd0, 8'h00, 20'h00000, 8'h05, 0, 20'h00055};
    vt[11] = '{1'b0, 1'b1, 3'd0, 8'h00, 20'h00000, 8'h09, 0, 20'h00000};

    // reset and init, with garbage traffic during init
    repeat (2) tick();
    chk("rst_rdy", 160'(b0.RDY), 160'(0));
    chk("rst_q", 160'(b0.Q), 160'(0));
    rst = 1'b0;
    b0.CEN = 1'b0;
    b0.WEN = 1'b0;
    b0.CADDR = 11'h7FF;
    b0.D = 20'hFFFFF;
    b0.A = {8{8'hFF}};
    wait_rdy(n);
    chk("init_len", 160'(n), 160'(256));
    chk("init_q", 160'(b0.Q), 160'(0));
    b0.WEN = 1'b1;
    tick();
    chk("init_rd255", 160'(b0.Q), 160'(0));

    // table-driven vectors
    for (int i = 0; i < 12; i++) begin
      b0.CEN = vt[i].cen;
      b0.WEN = vt[i].wen;
      b0.CADDR = {vt[i].bank, vt[i].word};
      b0.D = vt[i].d;
      b0.A = {8{vt[i].a}};
      tick();
      chk($sformatf("vec%0d", i), 160'(b0.Q[vt[i].rb*20 +: 20]),
          160'(vt[i].exp));
    end

    // fill and parallel readback
    for (int i = 0; i < 2048; i++) begin
      logic [19:0] v;
      v = 20'($urandom);
      m[i/256][i%256] = v;
      wr0(11'(i), v);
    end
    b0.WEN = 1'b1;
    for (int c = 0; c < 256; c++) begin
      for (int b = 0; b < 8; b++) begin
        ra[b] = 8'($urandom);
        b0.A[b*8 +: 8] = ra[b];
      end
      tick();
      for (int b = 0; b < 8; b++) begin
        chk($sformatf("fill_b%0d", b), 160'(b0.Q[b*20 +: 20]),
            160'(m[b][ra[b]]));
      end
    end

    // reset mid-operation
    for (int i = 0; i < 2048; i++) wr0(11'(i), 20'hFFFFF);
    for (int i = 0; i < 50; i++) wr0(11'(i), 20'hFFFFF);
    rst = 1'b1;
    b0.CEN = 1'b1;
    repeat (2) tick();
    chk("mid_q", 160'(b0.Q), 160'(0));
    rst = 1'b0;
    wait_rdy(n);
    chk("mid_len", 160'(n), 160'(256));
    b0.CEN = 1'b0;
    b0.WEN = 1'b1;
    for (int w = 0; w < 256; w++) begin
      b0.A = {8{8'(w)}};
      tick();
      chk("mid_zero", 160'(b0.Q), 160'(0));
    end

    // second reset at init count 100
    b0.CEN = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (100) tick();
    chk("rerst_low", 160'(b0.RDY), 160'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_rdy(n);
    chk("rerst_len", 160'(n), 160'(256));

    // write-old collision on the 6-bank instance
    chk("b1_rdy", 160'(b1.RDY), 160'(1));
    wr1({3'd3, 4'hA}, 20'hABCDE, 4'h0);
    wr1({3'd3, 4'hA}, 20'h12345, 4'hA);
    chk("wf0_old", 160'(b1.Q[3*20 +: 20]), 160'(20'hABCDE));
    b1.WEN = 1'b1;
    tick();
    chk("wf0_new", 160'(b1.Q[3*20 +: 20]), 160'(20'h12345));

    // out-of-range bank writes
    for (int b = 0; b < 6; b++) wr1({3'(b), 4'h2}, 20'(32'h100 + b), 4'h0);
    wr1({3'd6, 4'h2}, 20'hFFFFF, 4'h2);
    wr1({3'd7, 4'h2}, 20'hEEEEE, 4'h2);
    b1.WEN = 1'b1;
    b1.A = {6{4'h2}};
    tick();
    for (int b = 0; b < 6; b++) begin
      chk($sformatf("oob_b%0d", b), 160'(b1.Q[b*20 +: 20]),
          160'(32'h100 + b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/banked_coef_sram.md
# banked_coef_sram

Parametrised multi-bank coefficient memory for the FIR filter datapath. It has one shared write port, addressed by bank and word, and BLKS independent registered read ports, one per bank, so every filter tap can fetch a coefficient in the same cycle. It generalises the fixed 8×256×20 bank array to configurable bank count, depth and width. It adds a self-clearing init sequencer and a selectable read-during-write collision mode.

## Interface
- BLKS, 8, number of banks and read ports (≥1).
- AW, 8, word-address width per bank; DEPTH = 2^AW.
- BW, 3, bank-select width in CADDR; 2^BW ≥ BLKS.
- DW, 20, data word width.
- WRITE_FIRST, 1, same-cycle collision: 1 = Q returns new D, 0 = Q returns old contents.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- CEN  in  1  chip enable, active low; high = no read, no write, Q holds.
- WEN  in  1  write enable, active low; effective only with CEN low.
- CADDR  in  BW+AW  write address: [BW+AW-1:AW] = bank, [AW-1:0] = word.
- D  in  DW  write data.
- A  in  BLKS*AW  read addresses; bank b uses A[b*AW +: AW].
- Q  out  BLKS*DW  registered read data; bank b drives Q[b*DW +: DW].
- RDY  out  1  high once the init clear has completed; low during init.

## Operation
- FSM states: INIT, READY.
- rst asserted: go to INIT, init counter = 0, RDY = 0, Q = 0.
  - This is asynchronous and takes effect from any state, including mid-init.
- INIT:
  - Each cycle, word `counter` of every bank is written with 0, then the counter increments.
  - After the write of word DEPTH-1, go to READY and set RDY = 1.
  - CEN, WEN, CADDR, D and A are ignored. Q stays 0.
- READY, CEN low, WEN low:
  - D is written to bank CADDR[bank], word CADDR[word].
  - A bank index ≥ BLKS drops the write silently; no bank changes.
- READY, CEN low:
  - Every bank b registers mem_b[A_b] into Q_b, whether or not a write happens in the same cycle.
- READY, CEN high: no memory change, and Q holds its previous value.
- Collision: a write to bank b, word w, in the same cycle that A_b == w.
  - WRITE_FIRST=1: Q_b ← D.
  - WRITE_FIRST=0: Q_b ← the prior contents.
  - The memory is updated in both modes.
  - Other banks are unaffected by the collision.
- X/Z on A or CADDR while CEN is high must not corrupt memory or Q.

## Timing
- Reset values: Q = 0 on all banks, RDY = 0, FSM = INIT, init counter = 0.
- Init duration: exactly DEPTH cycles.
  - RDY rises on the DEPTH-th posedge after rst deasserts.
  - The first accepted access is on the edge after RDY is seen high.
- Read latency: 1 cycle. An address presented before posedge N appears on Q just after posedge N.
- Write latency: 0 cycles. A write at posedge N is visible to a read issued at posedge N+1; with WRITE_FIRST=1 it is already visible at posedge N.
- Throughput: one write plus BLKS reads per cycle, with no stalls once RDY = 1.
- Init counter: AW+1 bits, so the terminal count DEPTH does not wrap.

## Test plan
1. Reset and init (default parameters):
   - Pulse rst for 2 cycles, then release -> RDY stays 0 for exactly 256 posedges, then goes to 1.
   - Read all A = 255 -> all Q = 0.
2. Fill and parallel readback:
   - Write random 20-bit values to all 2048 CADDR values.
   - Then read all 8 banks with random A for 256 cycles -> each Q_b equals the model value 1 cycle later.
3. Collision, WRITE_FIRST=1:
   - Preload bank 3, word 0x10 with 0xABCDE.
   - Write 0x12345 there while A_3 = 0x10 -> Q_3 = 0x12345.
   - Rerun with WRITE_FIRST=0 -> Q_3 = 0xABCDE, then 0x12345 on the next read.
4. CEN high hold:
   - Read Q_0 = 0x00055, then raise CEN while driving WEN low and changing A -> Q unchanged and memory unchanged.
5. Reset mid-operation:
   - Write 0xFFFFF everywhere, assert rst mid-stream, and wait for RDY -> every word reads 0.
   - Assert rst again at init count 100 -> RDY rises 256 cycles after the second release.
6. Out-of-range bank:
   - With BLKS=6, BW=3, write CADDR bank 6 and bank 7 -> banks 0–5 are unchanged and no error occurs.
